// File: rtl/voice_scheduler_pkg.sv
// Shared types and default widths for the voice scheduler slice.
// Holds the scheduler state encoding and the sine-LUT midpoint helper.
package voice_scheduler_pkg;

    localparam int DEF_NUM_VOICES       = 6;
    localparam int DEF_ACCUMULATOR_BITS = 24;
    localparam int DEF_OUTPUT_BITS      = 12;
    localparam int DEF_VOICE_BITS       = 3;
    localparam int DEF_MIX_BITS         = DEF_OUTPUT_BITS + DEF_VOICE_BITS;

    // Offset-binary zero point of an unsigned LUT sample of the given width.
    function automatic int lut_mid_for(input int bits);
        return 1 << (bits - 1);
    endfunction

    localparam int LUT_MID = lut_mid_for(DEF_OUTPUT_BITS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        MIX    = 2'd2,
        DONE   = 2'd3
    } sched_state_t;

endpackage

// File: rtl/voice_scheduler_phase_bank.sv
// Per-voice tuning, gate and phase storage with config write port and indexed advance.
// VOICE_SCHEDULER_PHASE_SYNC_EN: a gate 0->1 write also restarts that voice's phase at 0.
module phase_accumulator_bank
    import voice_scheduler_pkg::*;
#(
    parameter int NUM_VOICES       = DEF_NUM_VOICES,
    parameter int ACCUMULATOR_BITS = DEF_ACCUMULATOR_BITS,
    parameter int VOICE_BITS       = DEF_VOICE_BITS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_we,
    input  logic [VOICE_BITS-1:0]       cfg_voice,
    input  logic [ACCUMULATOR_BITS-1:0] cfg_tuning,
    input  logic                        cfg_gate,
    input  logic [VOICE_BITS-1:0]       rd_voice,
    input  logic                        upd_en,
    output logic [ACCUMULATOR_BITS-1:0] rd_phase_next,
    output logic                        rd_gate
);

    logic [ACCUMULATOR_BITS-1:0] tuning_q [NUM_VOICES];
    logic [ACCUMULATOR_BITS-1:0] tuning_d [NUM_VOICES];
    logic [ACCUMULATOR_BITS-1:0] phase_q  [NUM_VOICES];
    logic [ACCUMULATOR_BITS-1:0] phase_d  [NUM_VOICES];
    logic                        gate_q   [NUM_VOICES];
    logic                        gate_d   [NUM_VOICES];

    logic [ACCUMULATOR_BITS-1:0] rd_phase;
    logic [ACCUMULATOR_BITS-1:0] rd_tuning;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            logic cfg_hit;
            logic advance;

            // Writes to indices beyond the last voice never match any slot.
            assign cfg_hit  = cfg_we && (cfg_voice == VOICE_BITS'(gi));
            assign advance  = upd_en && (rd_voice == VOICE_BITS'(gi)) && gate_q[gi];

            assign tuning_d[gi] = cfg_hit ? cfg_tuning : tuning_q[gi];
            assign gate_d[gi]   = cfg_hit ? cfg_gate   : gate_q[gi];

`ifdef VOICE_SCHEDULER_PHASE_SYNC_EN
            logic onset;
            // The clear overrides a same-cycle advance; the advance only happens when already gated anyway.
            assign onset       = cfg_hit && cfg_gate && !gate_q[gi];
            assign phase_d[gi] = onset   ? '0
                               : advance ? phase_q[gi] + tuning_q[gi]
                               :           phase_q[gi];
`else
            assign phase_d[gi] = advance ? phase_q[gi] + tuning_q[gi] : phase_q[gi];
`endif
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                tuning_q[i] <= '0;
                phase_q[i]  <= '0;
                gate_q[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                tuning_q[i] <= tuning_d[i];
                phase_q[i]  <= phase_d[i];
                gate_q[i]   <= gate_d[i];
            end
        end
    end

    // Indexed read reflects pre-write state, so a colliding config write lands after the update.
    always_comb begin
        rd_phase  = '0;
        rd_tuning = '0;
        rd_gate   = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (rd_voice == VOICE_BITS'(i)) begin
                rd_phase  = phase_q[i];
                rd_tuning = tuning_q[i];
                rd_gate   = gate_q[i];
            end
        end
        rd_phase_next = rd_gate ? rd_phase + rd_tuning : rd_phase;
    end

endmodule

// File: rtl/voice_scheduler.sv
// Time-multiplexes one shared sine LUT across NUM_VOICES phase accumulators and mixes the result.
// Build option VOICE_SCHEDULER_PHASE_SYNC_EN is handled inside phase_accumulator_bank.
module voice_scheduler
    import voice_scheduler_pkg::*;
#(
    parameter int NUM_VOICES       = DEF_NUM_VOICES,
    parameter int ACCUMULATOR_BITS = DEF_ACCUMULATOR_BITS,
    parameter int OUTPUT_BITS      = DEF_OUTPUT_BITS,
    parameter int VOICE_BITS       = DEF_VOICE_BITS,
    parameter int MIX_BITS         = OUTPUT_BITS + VOICE_BITS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        sample_tick,
    input  logic                        cfg_we,
    input  logic [VOICE_BITS-1:0]       cfg_voice,
    input  logic [ACCUMULATOR_BITS-1:0] cfg_tuning,
    input  logic                        cfg_gate,
    output logic [ACCUMULATOR_BITS-1:0] lut_phase,
    input  logic [OUTPUT_BITS-1:0]      lut_data,
    output logic signed [MIX_BITS-1:0]  mix_out,
    output logic                        mix_valid,
    output logic                        busy,
    output logic                        overrun
);

    localparam int                    LUT_MID_L  = lut_mid_for(OUTPUT_BITS);
    localparam logic [VOICE_BITS-1:0] LAST_VOICE = VOICE_BITS'(NUM_VOICES - 1);

    sched_state_t                  state_q, state_d;
    logic [VOICE_BITS-1:0]         v_q, v_d;
    logic signed [MIX_BITS-1:0]    acc_q, acc_d;
    logic [ACCUMULATOR_BITS-1:0]   lut_phase_q, lut_phase_d;
    logic signed [MIX_BITS-1:0]    mix_out_q, mix_out_d;
    logic                          mix_valid_q, mix_valid_d;
    logic                          busy_q, busy_d;
    logic                          overrun_q, overrun_d;

    logic                          upd_en;
    logic [ACCUMULATOR_BITS-1:0]   bank_phase_next;
    logic                          bank_gate;
    logic signed [MIX_BITS-1:0]    sample_s;
    logic signed [MIX_BITS-1:0]    acc_sum;

    phase_accumulator_bank #(
        .NUM_VOICES       (NUM_VOICES),
        .ACCUMULATOR_BITS (ACCUMULATOR_BITS),
        .VOICE_BITS       (VOICE_BITS)
    ) u_bank (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_we        (cfg_we),
        .cfg_voice     (cfg_voice),
        .cfg_tuning    (cfg_tuning),
        .cfg_gate      (cfg_gate),
        .rd_voice      (v_q),
        .upd_en        (upd_en),
        .rd_phase_next (bank_phase_next),
        .rd_gate       (bank_gate)
    );

    // Offset-binary LUT sample re-centred to signed; ungated voices add nothing.
    always_comb begin
        sample_s = $signed(MIX_BITS'(lut_data)) - $signed(MIX_BITS'(LUT_MID_L));
        acc_sum  = bank_gate ? acc_q + sample_s : acc_q;
    end

    always_comb begin
        state_d     = state_q;
        v_d         = v_q;
        acc_d       = acc_q;
        lut_phase_d = lut_phase_q;
        mix_out_d   = mix_out_q;
        mix_valid_d = 1'b0;
        busy_d      = busy_q;
        upd_en      = 1'b0;
        overrun_d   = overrun_q | (sample_tick && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    acc_d   = '0;
                    v_d     = '0;
                    busy_d  = 1'b1;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                upd_en      = 1'b1;
                lut_phase_d = bank_phase_next;
                state_d     = MIX;
            end
            MIX: begin
                acc_d = acc_sum;
                if (v_q == LAST_VOICE) begin
                    // Load the result on entry to DONE so mix_out and mix_valid appear together.
                    mix_out_d   = acc_sum;
                    mix_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    v_d     = v_q + VOICE_BITS'(1);
                    state_d = UPDATE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            v_q         <= '0;
            acc_q       <= '0;
            lut_phase_q <= '0;
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            v_q         <= v_d;
            acc_q       <= acc_d;
            lut_phase_q <= lut_phase_d;
            mix_out_q   <= mix_out_d;
            mix_valid_q <= mix_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign lut_phase = lut_phase_q;
    assign mix_out   = mix_out_q;
    assign mix_valid = mix_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Self-checking bench for voice_scheduler: ideal sine LUT, per-voice reference model, scenario tasks.
// Honours VOICE_SCHEDULER_PHASE_SYNC_EN in its model when the build defines it.
module tb_voice_scheduler;
    import voice_scheduler_pkg::*;

    localparam int NV = 6;
    localparam int AB = 24;
    localparam int OB = 12;
    localparam int VB = 3;
    localparam int MB = OB + VB;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 sample_tick = 1'b0;
    logic                 cfg_we = 1'b0;
    logic [VB-1:0]        cfg_voice = '0;
    logic [AB-1:0]        cfg_tuning = '0;
    logic                 cfg_gate = 1'b0;
    logic [AB-1:0]        lut_phase;
    logic [OB-1:0]        lut_data;
    logic signed [MB-1:0] mix_out;
    logic                 mix_valid;
    logic                 busy;
    logic                 overrun;

    logic [OB-1:0] lut_tbl [1024];
    assign lut_data = lut_tbl[lut_phase[AB-1 -: 10]];

    always #5 clk = ~clk;

    voice_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .cfg_we      (cfg_we),
        .cfg_voice   (cfg_voice),
        .cfg_tuning  (cfg_tuning),
        .cfg_gate    (cfg_gate),
        .lut_phase   (lut_phase),
        .lut_data    (lut_data),
        .mix_out     (mix_out),
        .mix_valid   (mix_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: what each string should hold after every write and tick.
    logic [AB-1:0] m_tun [NV];
    logic [AB-1:0] m_ph  [NV];
    bit            m_gate[NV];
    logic [AB-1:0] exp_phase[NV];
    int            exp_mix;

    logic [AB-1:0]        got_phase[NV];
    logic signed [MB-1:0] got_mix;
    int                   got_lat;

    function automatic void build_lut();
        for (int i = 0; i < 1024; i++) begin
            real s;
            int  iv;
            s  = 2047.0 * $sin(2.0 * 3.14159265358979 * i / 1024.0);
            iv = (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(-s + 0.5);
            lut_tbl[i] = OB'(iv + LUT_MID);
        end
    endfunction

    function automatic void model_reset();
        for (int v = 0; v < NV; v++) begin
            m_tun[v] = '0; m_ph[v] = '0; m_gate[v] = 1'b0;
        end
    endfunction

    function automatic void model_write(input int v, input logic [AB-1:0] tw, input bit g);
        if (v < NV) begin
`ifdef VOICE_SCHEDULER_PHASE_SYNC_EN
            if (g && !m_gate[v]) m_ph[v] = '0;
`endif
            m_tun[v]  = tw;
            m_gate[v] = g;
        end
    endfunction

    function automatic void model_tick();
        exp_mix = 0;
        for (int v = 0; v < NV; v++) begin
            if (m_gate[v]) begin
                m_ph[v] = m_ph[v] + m_tun[v];
                exp_mix += int'(lut_tbl[m_ph[v][AB-1 -: 10]]) - LUT_MID;
            end
            exp_phase[v] = m_ph[v];
        end
    endfunction

    task automatic reset_dut();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        model_reset();
    endtask

    task automatic cfg_write(input int v, input logic [AB-1:0] tw, input bit g);
        @(negedge clk);
        cfg_we = 1'b1; cfg_voice = VB'(v); cfg_tuning = tw; cfg_gate = g;
        @(negedge clk);
        cfg_we = 1'b0;
        model_write(v, tw, g);
    endtask

    // One tick; optional config write driven during cycle wr_k after the tick (0 = none).
    task automatic do_tick(input int wr_k, input int wr_v, input logic [AB-1:0] wr_tw, input bit wr_g);
        int k;
        bit seen;
        for (int v = 0; v < NV; v++) got_phase[v] = 'x;
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        k = 1; seen = 1'b0; got_lat = -1; got_mix = 'x;
        while (!seen && k <= 40) begin
            if (k == wr_k) begin
                cfg_we = 1'b1; cfg_voice = VB'(wr_v); cfg_tuning = wr_tw; cfg_gate = wr_g;
            end else begin
                cfg_we = 1'b0;
            end
            if (k >= 2 && k % 2 == 0 && k / 2 - 1 < NV) got_phase[k/2-1] = lut_phase;
            if (mix_valid === 1'b1) begin
                seen = 1'b1; got_lat = k; got_mix = mix_out;
            end else begin
                @(negedge clk); k++;
            end
        end
        cfg_we = 1'b0;
        model_tick();
        if (wr_k > 0) model_write(wr_v, wr_tw, wr_g);
        $display("tick: latency=%0d mix_out=%0d phase0=%06h", got_lat, got_mix, got_phase[0]);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int mv;
        repeat (3) @(negedge clk);
        n_cmp++; if (lut_phase !== '0) begin n_err++; $display("FAIL por_lut_phase: got %06h expected 000000", lut_phase); end
        n_cmp++; if (mix_out !== '0) begin n_err++; $display("FAIL por_mix_out: got %0d expected 0", mix_out); end
        n_cmp++; if (mix_valid !== 1'b0) begin n_err++; $display("FAIL por_mix_valid: got %b expected 0", mix_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL por_busy: got %b expected 0", busy); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL por_overrun: got %b expected 0", overrun); end
        rst_n = 1'b1;
        model_reset();

        cfg_write(0, 24'h400000, 1'b1);
        cfg_write(2, 24'h100000, 1'b1);
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midseq_busy: got %b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (lut_phase !== '0) begin n_err++; $display("FAIL midrst_lut_phase: got %06h expected 000000", lut_phase); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_cmp++; if (mix_out !== '0) begin n_err++; $display("FAIL midrst_mix_out: got %0d expected 0", mix_out); end
        mv = 0;
        repeat (2) begin @(negedge clk); if (mix_valid === 1'b1) mv++; end
        rst_n = 1'b1;
        model_reset();
        repeat (20) begin @(negedge clk); if (mix_valid === 1'b1) mv++; end
        n_cmp++; if (mv != 0) begin n_err++; $display("FAIL midrst_no_valid: got %0d pulses expected 0", mv); end

        do_tick(0, 0, '0, 1'b0);
        n_cmp++; if (got_lat != 2 * NV + 1) begin n_err++; $display("FAIL postrst_latency: got %0d expected %0d", got_lat, 2 * NV + 1); end
        n_cmp++; if (got_mix !== MB'(0)) begin n_err++; $display("FAIL postrst_mix: got %0d expected 0", got_mix); end
        n_cmp++; if (got_phase[0] !== '0) begin n_err++; $display("FAIL postrst_phase0: got %06h expected 000000", got_phase[0]); end
    endtask

    task automatic test_single_voice();
        logic [AB-1:0] ph_tbl [4];
        int            mx_tbl [4];
        ph_tbl = '{24'h400000, 24'h800000, 24'hC00000, 24'h000000};
        mx_tbl = '{2047, 0, -2047, 0};
        cfg_write(0, 24'h400000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            do_tick(0, 0, '0, 1'b0);
            n_cmp++; if (got_lat != 13) begin n_err++; $display("FAIL single_latency[%0d]: got %0d expected 13", i, got_lat); end
            n_cmp++; if (got_phase[0] !== ph_tbl[i]) begin n_err++; $display("FAIL single_phase[%0d]: got %06h expected %06h", i, got_phase[0], ph_tbl[i]); end
            n_cmp++; if (got_mix !== MB'(mx_tbl[i])) begin n_err++; $display("FAIL single_mix[%0d]: got %0d expected %0d", i, got_mix, mx_tbl[i]); end
            n_cmp++; if (got_mix !== MB'(exp_mix)) begin n_err++; $display("FAIL single_model[%0d]: got %0d expected %0d", i, got_mix, exp_mix); end
        end
    endtask

    task automatic test_all_voices();
        reset_dut();
        for (int v = 0; v < NV; v++) cfg_write(v, 24'h400000, 1'b1);
        do_tick(0, 0, '0, 1'b0);
        n_cmp++; if (got_mix !== MB'(12282)) begin n_err++; $display("FAIL all_mix_full: got %0d expected 12282", got_mix); end
        for (int v = 1; v < NV; v++) cfg_write(v, 24'h400000, 1'b0);
        do_tick(0, 0, '0, 1'b0);
        n_cmp++; if (got_mix !== MB'(0)) begin n_err++; $display("FAIL all_mix_v0only: got %0d expected 0", got_mix); end
        n_cmp++; if (got_phase[1] !== 24'h400000) begin n_err++; $display("FAIL all_frozen_phase1: got %06h expected 400000", got_phase[1]); end
        n_cmp++; if (got_phase[0] !== 24'h800000) begin n_err++; $display("FAIL all_phase0: got %06h expected 800000", got_phase[0]); end
    endtask

    // Drives two ticks 'gap' cycles apart; reports number of mix_valid pulses seen.
    task automatic tick_pair(input int gap, output int mv);
        mv = 0;
        for (int c = 0; c < gap + 30; c++) begin
            @(negedge clk);
            if (mix_valid === 1'b1) mv++;
            sample_tick = (c == 0 || c == gap);
        end
        sample_tick = 1'b0;
    endtask

    task automatic test_overrun();
        int mv;
        reset_dut();
        cfg_write(0, 24'h400000, 1'b1);
        tick_pair(5, mv);
        n_cmp++; if (mv != 1) begin n_err++; $display("FAIL ovr5_valid_count: got %0d expected 1", mv); end
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr5_flag: got %b expected 1", overrun); end
        repeat (20) @(negedge clk);
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end

        reset_dut();
        tick_pair(14, mv);
        n_cmp++; if (mv != 2) begin n_err++; $display("FAIL ovr14_valid_count: got %0d expected 2", mv); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr14_flag: got %b expected 0", overrun); end

        reset_dut();
        tick_pair(13, mv);
        n_cmp++; if (mv != 1) begin n_err++; $display("FAIL ovr13_valid_count: got %0d expected 1", mv); end
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr13_flag: got %b expected 1", overrun); end
    endtask

    task automatic test_collision();
        reset_dut();
        cfg_write(2, 24'h200000, 1'b1);
        do_tick(0, 0, '0, 1'b0);
        // Cycle 5 after the tick is voice 2's UPDATE.
        do_tick(5, 2, 24'h100000, 1'b1);
        n_cmp++; if (got_phase[2] !== 24'h400000) begin n_err++; $display("FAIL coll_old_tuning: got %06h expected 400000", got_phase[2]); end
        n_cmp++; if (got_mix !== MB'(2047)) begin n_err++; $display("FAIL coll_mix: got %0d expected 2047", got_mix); end
        do_tick(0, 0, '0, 1'b0);
        n_cmp++; if (got_phase[2] !== 24'h500000) begin n_err++; $display("FAIL coll_new_tuning: got %06h expected 500000", got_phase[2]); end
        n_cmp++; if (got_mix !== MB'(exp_mix)) begin n_err++; $display("FAIL coll_new_mix: got %0d expected %0d", got_mix, exp_mix); end

        cfg_write(7, 24'hABCDEF, 1'b1);
        do_tick(0, 0, '0, 1'b0);
        n_cmp++; if (got_phase[2] !== 24'h600000) begin n_err++; $display("FAIL badvoice_phase2: got %06h expected 600000", got_phase[2]); end
        n_cmp++; if (got_mix !== MB'(exp_mix)) begin n_err++; $display("FAIL badvoice_mix: got %0d expected %0d", got_mix, exp_mix); end
        for (int v = 0; v < NV; v++) begin
            n_cmp++; if (got_phase[v] !== exp_phase[v]) begin n_err++; $display("FAIL badvoice_phase[%0d]: got %06h expected %06h", v, got_phase[v], exp_phase[v]); end
        end
    endtask

    task automatic test_phase_sync();
        logic [AB-1:0] want;
        reset_dut();
        cfg_write(0, 24'h400000, 1'b1);
        do_tick(0, 0, '0, 1'b0);
        n_cmp++; if (got_phase[0] !== 24'h400000) begin n_err++; $display("FAIL sync_setup_phase: got %06h expected 400000", got_phase[0]); end
        cfg_write(0, 24'h400000, 1'b0);
        cfg_write(0, 24'h400000, 1'b1);
        do_tick(0, 0, '0, 1'b0);
`ifdef VOICE_SCHEDULER_PHASE_SYNC_EN
        want = 24'h400000;
`else
        want = 24'h800000;
`endif
        n_cmp++; if (got_phase[0] !== want) begin n_err++; $display("FAIL sync_regate_phase: got %06h expected %06h", got_phase[0], want); end
        n_cmp++; if (got_phase[0] !== exp_phase[0]) begin n_err++; $display("FAIL sync_model_phase: got %06h expected %06h", got_phase[0], exp_phase[0]); end
    endtask

    task automatic test_random();
        reset_dut();
        for (int it = 0; it < 30; it++) begin
            int nw;
            int cv;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++)
                cfg_write($urandom_range(0, 7), AB'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                // Retune a voice during its own UPDATE cycle, leaving its gate alone.
                cv = $urandom_range(0, NV - 1);
                do_tick(2 * cv + 1, cv, AB'($urandom), m_gate[cv]);
            end else begin
                do_tick(0, 0, '0, 1'b0);
            end
            n_cmp++; if (got_lat != 13) begin n_err++; $display("FAIL rand_latency[%0d]: got %0d expected 13", it, got_lat); end
            n_cmp++; if (got_mix !== MB'(exp_mix)) begin n_err++; $display("FAIL rand_mix[%0d]: got %0d expected %0d", it, got_mix, exp_mix); end
            for (int v = 0; v < NV; v++) begin
                n_cmp++; if (got_phase[v] !== exp_phase[v]) begin n_err++; $display("FAIL rand_phase[%0d][%0d]: got %06h expected %06h", it, v, got_phase[v], exp_phase[v]); end
            end
        end
    endtask

    initial begin
        build_lut();
        model_reset();
        test_reset();
        test_single_voice();
        test_all_voices();
        test_overrun();
        test_collision();
        test_phase_sync();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
